// File: rtl/sobel_window_gen_if.sv
// rtl/sobel_window_gen_if.sv - pixel read stream in, 3x3 window stream out, for sobel_window_gen
// The beat counter side drives the master view; the window generator uses the slave view.
interface sobel_window_gen_if #(
  parameter int PIXELWIDTH        = 8,
  parameter int PIXELCOUNTERWIDTH = 20
);
  logic                           started;
  logic                           process_valid;
  logic [PIXELCOUNTERWIDTH-1:0]   pixel_addr;
  logic [PIXELWIDTH-1:0]          pixel_data;
  logic                           win_valid;
  logic [9*PIXELWIDTH-1:0]        win_pixels;
  logic [PIXELCOUNTERWIDTH-1:0]   centre_addr;
  logic                           frame_done;

  modport master (
    output started, process_valid, pixel_addr, pixel_data,
    input  win_valid, win_pixels, centre_addr, frame_done
  );

  modport slave (
    input  started, process_valid, pixel_addr, pixel_data,
    output win_valid, win_pixels, centre_addr, frame_done
  );
endinterface

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - 3x3 neighbourhood window generator for the Sobel gradient stage
// Two line buffers plus a shifting 3x3 register array; only interior centres produce a window.
module sobel_window_gen #(
  parameter int IMG_WIDTH         = 16,
  parameter int IMG_HEIGHT        = 16,
  parameter int PIXELWIDTH        = 8,
  parameter int PIXELCOUNTERWIDTH = 20,
  parameter int MEMLATENCY        = 1
) (
  input  logic              clk,
  input  logic              reset,
  sobel_window_gen_if.slave win_if
);
  localparam int PW = PIXELWIDTH;
  localparam int AW = PIXELCOUNTERWIDTH;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST        = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST        = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST_VALID = CW'(2);
  localparam logic [RW-1:0] ROW_FIRST_VALID = RW'(2);
  localparam logic [AW-1:0] CENTRE_OFFSET   = AW'(IMG_WIDTH + 1);

  logic            proc_q [MEMLATENCY];
  logic [AW-1:0]   addr_q [MEMLATENCY];
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [PW-1:0]   lb0_q [IMG_WIDTH];
  logic [PW-1:0]   lb1_q [IMG_WIDTH];
  logic [PW-1:0]   win_q [9];
  logic [PW-1:0]   win_d [9];
  logic [9*PW-1:0] win_packed;
  logic [9*PW-1:0] win_pixels_q;
  logic [AW-1:0]   centre_addr_q;
  logic            win_valid_q;
  logic            frame_done_q;
  logic            accept;
  logic            valid_hit;
  logic            frame_hit;
  logic [AW-1:0]   accept_addr;

  // Delay process/address to line up with the memory read data.
  always_ff @(posedge clk) begin
    if (reset || !win_if.started) begin
      for (int i = 0; i < MEMLATENCY; i++) begin
        proc_q[i] <= 1'b0;
        addr_q[i] <= '0;
      end
    end else begin
      proc_q[0] <= win_if.process_valid;
      addr_q[0] <= win_if.pixel_addr;
      for (int i = 1; i < MEMLATENCY; i++) begin
        proc_q[i] <= proc_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign accept      = proc_q[MEMLATENCY-1];
  assign accept_addr = addr_q[MEMLATENCY-1];

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      win_d[i] = win_q[i];
    end
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = lb1_q[col_q];
      win_d[5] = lb0_q[col_q];
      win_d[8] = win_if.pixel_data;
    end
  end

  always_comb begin
    win_packed = '0;
    for (int i = 0; i < 9; i++) begin
      win_packed[PW*i +: PW] = win_d[i];
    end
  end

  // Gating on col>=2 keeps every emitted window inside a single row.
  assign valid_hit = accept && (row_q >= ROW_FIRST_VALID) && (col_q >= COL_FIRST_VALID);
  assign frame_hit = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q         <= '0;
      row_q         <= '0;
      win_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      win_pixels_q  <= '0;
      centre_addr_q <= '0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else if (!win_if.started) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= valid_hit;
      frame_done_q <= frame_hit;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= win_d[i];
      end
      if (valid_hit) begin
        win_pixels_q  <= win_packed;
        centre_addr_q <= accept_addr - CENTRE_OFFSET;
      end
    end
  end

  // Line buffers are left unreset; row gating hides stale contents.
  always_ff @(posedge clk) begin
    if (!reset && win_if.started && accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= win_if.pixel_data;
    end
  end

  assign win_if.win_valid   = win_valid_q;
  assign win_if.win_pixels  = win_pixels_q;
  assign win_if.centre_addr = centre_addr_q;
  assign win_if.frame_done  = frame_done_q;
endmodule
